// File: rtl/imm_decode_queue.sv
// imm_decode_queue: decode-stage FIFO that classifies immediate formats at enqueue and sequences HALT/flush.
// Ports: clk/rst (async active-high) | flush drops all buffered entries and returns to RUN
//   in_valid/in_ready/in_inst/in_pc: fetch side, opcode = in_inst[15:11]
//   out_valid/out_ready/out_inst/out_pc/out_ext_sel/out_imm: execute side, head of queue
//   halted: HALT has been handed downstream | issue_cnt: saturating pop count (IMM_DECODE_STATS_EN only)
module imm_decode_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_inst,
  input  logic [15:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_inst,
  output logic [15:0] out_pc,
  output logic [2:0]  out_ext_sel,
  output logic [15:0] out_imm,
  output logic        halted
`ifdef IMM_DECODE_STATS_EN
  , output logic [15:0] issue_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] inst_m [DEPTH];
  logic [15:0] pc_m [DEPTH];
  logic [15:0] imm_m [DEPTH];
  logic [2:0] sel_m [DEPTH];
  logic [15:0] last_inst_q, last_pc_q, last_imm_q;
  logic [2:0] last_sel_q, in_sel;
  logic [15:0] in_imm;
  logic push, pop;

  function automatic logic [2:0] fmt(input logic [4:0] op);
    case (op) inside
      5'b10010: fmt = 3'b001;
      5'b0100?, 5'b1000?, 5'b10011: fmt = 3'b010;
      5'b011??, 5'b11000, 5'b00101, 5'b00111: fmt = 3'b100;
      5'b00100, 5'b00110: fmt = 3'b110;
      default: fmt = 3'b000;
    endcase
  endfunction

  assign in_sel = fmt(in_inst[15:11]);
  assign in_imm = in_sel == 3'b001 ? {8'b0, in_inst[7:0]} :
                  in_sel == 3'b010 ? {{11{in_inst[4]}}, in_inst[4:0]} :
                  in_sel == 3'b100 ? {{8{in_inst[7]}}, in_inst[7:0]} :
                  in_sel == 3'b110 ? {{5{in_inst[10]}}, in_inst[10:0]} :
                  {11'b0, in_inst[4:0]};
  assign in_ready = state_q == RUN && cnt_q < CW'(DEPTH) && !flush;
  assign out_valid = cnt_q != '0;
  assign halted = state_q == HALTED;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready & ~flush;
  // While empty the outputs show the most recently issued entry rather than stale storage.
  assign out_inst = out_valid ? inst_m[rd_q] : last_inst_q;
  assign out_pc = out_valid ? pc_m[rd_q] : last_pc_q;
  assign out_imm = out_valid ? imm_m[rd_q] : last_imm_q;
  assign out_ext_sel = out_valid ? sel_m[rd_q] : last_sel_q;

  // No pushes are accepted after HALT, so HALT is always the last entry: popping with one left drains it.
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    state_d = state_q == RUN && push && in_inst[15:11] == 5'b0 ? HALT_PEND :
              state_q == HALT_PEND && pop && cnt_q == CW'(1) ? HALTED : state_q;
    if (flush && state_q != HALTED) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      last_inst_q <= '0;
      last_pc_q <= '0;
      last_imm_q <= '0;
      last_sel_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_m[i] <= '0;
        pc_m[i] <= '0;
        imm_m[i] <= '0;
        sel_m[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      if (push) begin
        inst_m[wr_q] <= in_inst;
        pc_m[wr_q] <= in_pc;
        imm_m[wr_q] <= in_imm;
        sel_m[wr_q] <= in_sel;
      end
      if (pop) begin
        last_inst_q <= inst_m[rd_q];
        last_pc_q <= pc_m[rd_q];
        last_imm_q <= imm_m[rd_q];
        last_sel_q <= sel_m[rd_q];
      end
    end
  end

`ifdef IMM_DECODE_STATS_EN
  logic [15:0] issue_q;
  assign issue_cnt = issue_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) issue_q <= '0;
    else if (pop && issue_q != 16'hFFFF) issue_q <= issue_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_imm_decode_queue.sv
// tb_imm_decode_queue: randomized scoreboard bench for imm_decode_queue against a queue-based reference model.
module tb_imm_decode_queue;
  localparam int DEPTH = 2;
  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [2:0]  sel;
  } exp_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_inst = 0, in_pc = 0;
  logic in_ready, out_valid, halted;
  logic [15:0] out_inst, out_pc, out_imm;
  logic [2:0] out_ext_sel;
`ifdef IMM_DECODE_STATS_EN
  logic [15:0] issue_cnt;
`endif
  exp_t sb[$];
  int mstate = 0;
  int npop = 0;
  int errors = 0, checks = 0;

  imm_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_ext_sel(out_ext_sel), .out_imm(out_imm), .halted(halted)
`ifdef IMM_DECODE_STATS_EN
    , .issue_cnt(issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] inst, input logic [15:0] pc);
    exp_t e;
    int op;
    int v;
    op = int'(inst[15:11]);
    if (op == 18) begin
      e.sel = 3'b001;
      v = int'(inst[7:0]);
    end else if (op inside {8, 9, 16, 17, 19}) begin
      e.sel = 3'b010;
      v = int'(inst[4:0]);
      if (v > 15) v -= 32;
    end else if (op inside {[12:15], 24, 5, 7}) begin
      e.sel = 3'b100;
      v = int'(inst[7:0]);
      if (v > 127) v -= 256;
    end else if (op inside {4, 6}) begin
      e.sel = 3'b110;
      v = int'(inst[10:0]);
      if (v > 1023) v -= 2048;
    end else begin
      e.sel = 3'b000;
      v = int'(inst[4:0]);
    end
    e.inst = inst;
    e.pc = pc;
    e.imm = v[15:0];
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] inst, input logic [15:0] pc,
                      input logic ordy, input logic fl);
    logic exp_rdy;
    @(posedge clk);
    #1;
    in_valid = iv;
    in_inst = inst;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    #1;
    exp_rdy = mstate == 0 && sb.size() < DEPTH && !fl;
    chk("in_ready", 16'(in_ready), 16'(exp_rdy));
    chk("out_valid", 16'(out_valid), 16'(sb.size() != 0));
    chk("halted", 16'(halted), 16'(mstate == 2));
`ifdef IMM_DECODE_STATS_EN
    chk("issue_cnt", issue_cnt, npop[15:0]);
`endif
    if (exp_rdy && iv) begin
      sb.push_back(model(inst, pc));
      if (inst[15:11] == 5'b0) mstate = 1;
    end
    if (fl && mstate != 2) begin
      sb.delete();
      mstate = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    in_valid = 0;
    out_ready = 0;
    flush = 0;
    sb.delete();
    mstate = 0;
    npop = 0;
    #12;
    rst = 0;
  endtask

  // Monitor: a pop happens at the next edge whenever the head is valid, taken and not flushed.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop: unexpected head inst %h expected none", out_inst);
      end else begin
        e = sb.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_pc", out_pc, e.pc);
        chk("out_ext_sel", 16'(out_ext_sel), 16'(e.sel));
        chk("out_imm", out_imm, e.imm);
        npop++;
        if (e.inst[15:11] == 5'b0) mstate = 2;
      end
    end
  end

  initial begin
    logic [15:0] r;
    #12;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_out_inst", out_inst, 16'h0);
    chk("rst_out_pc", out_pc, 16'h0);
    chk("rst_out_imm", out_imm, 16'h0);
    chk("rst_out_sel", 16'(out_ext_sel), 16'h0);
`ifdef IMM_DECODE_STATS_EN
    chk("rst_issue_cnt", issue_cnt, 16'h0);
`endif
    rst = 0;
    step(1, 16'h4007, 16'h0010, 1, 0);
    step(1, 16'h601F, 16'h0012, 1, 0);
    step(1, 16'h60F0, 16'h0014, 1, 0);
    step(1, 16'h2405, 16'h0016, 1, 0);
    step(1, 16'h90FF, 16'h0018, 1, 0);
    step(0, 16'h0, 16'h0, 1, 0);
    step(0, 16'h0, 16'h0, 1, 0);
    step(1, 16'h4011, 16'h0020, 0, 0);
    step(1, 16'h4012, 16'h0022, 0, 0);
    step(1, 16'h4013, 16'h0024, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0);
    step(0, 16'h0, 16'h0, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0);
    step(0, 16'h0, 16'h0, 1, 0);
    step(1, 16'h0800, 16'h0030, 1, 0);
    step(1, 16'h0000, 16'h0032, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h4001, 16'h0034, 1, 0);
    do_reset();
    step(1, 16'h0800, 16'h0040, 0, 0);
    step(1, 16'h0000, 16'h0042, 0, 0);
    step(1, 16'h4003, 16'h0044, 0, 1);
    step(0, 16'h0, 16'h0, 0, 0);
    step(1, 16'h4002, 16'h0046, 1, 0);
    step(0, 16'h0, 16'h0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      if (mstate == 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        r = 16'($urandom);
        if (r[15:11] == 5'b0 && $urandom_range(0, 7) != 0) r[15:11] = 5'b01000;
        step($urandom_range(0, 3) != 0, r, 16'($urandom), $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0);
      end
    end
    step(0, 16'h0, 16'h0, 1, 0);
    do_reset();
    step(0, 16'h0, 16'h0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imm_decode_queue.md
Name: imm_decode_queue

Overview:
Decode-stage front end that buffers fetched instructions in a small FIFO and classifies each opcode's immediate format at enqueue. It forms the 16-bit extended immediate and presents instruction, PC, format code and immediate to the execute stage over a valid/ready handshake. It also sequences HALT (opcode 5'b00000) and pipeline flush.

Parameters:
DEPTH, 2, FIFO entries; power of two, 2..8.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
flush  input  1  discard all buffered instructions; return to RUN
in_valid  input  1  fetch offers an instruction
in_ready  output  1  queue accepts an instruction this cycle
in_inst  input  16  instruction word; opcode = in_inst[15:11]
in_pc  input  16  PC of in_inst
out_valid  output  1  head entry valid
out_ready  input  1  execute consumes head entry
out_inst  output  16  head instruction
out_pc  output  16  head PC
out_ext_sel  output  3  immediate format code of head
out_imm  output  16  extended immediate of head
halted  output  1  HALT has been handed downstream

Behaviour:
- One clock domain (clk), asynchronous active-high reset (rst).
- Reset values: FIFO empty, state RUN, out_valid=0, in_ready=1, halted=0, out_inst/out_pc/out_imm=16'h0000, out_ext_sel=3'b000.
- Push on in_valid & in_ready. Pop on out_valid & out_ready. Push and pop in the same cycle are both allowed.
- in_ready = (state==RUN) & (count<DEPTH) & ~flush. It is registered-state only, with no path from out_ready.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1. All out_* are driven from storage; there is no combinational in->out path.
- Format decode is done at enqueue and stored per entry, keyed by the opcode:
  - 3'b000 ZE5: 01010, 01011, 10100-10111. imm = {11'b0, inst[4:0]}
  - 3'b001 ZE8: 10010. imm = {8'b0, inst[7:0]}
  - 3'b010 SE5: 01000, 01001, 10000, 10001, 10011. imm = {{11{inst[4]}}, inst[4:0]}
  - 3'b100 SE8: 01100-01111, 11000, 00101, 00111. imm = {{8{inst[7]}}, inst[7:0]}
  - 3'b110 SE11: 00100, 00110. imm = {{5{inst[10]}}, inst[10:0]}
  - All other opcodes: 3'b000, imm = {11'b0, inst[4:0]}.
- When out_valid=0, out_* hold their last values. The bench checks them only while out_valid=1.
- FSM states:
  - RUN: accepting. Pushing opcode 00000 -> HALT_PEND.
  - HALT_PEND: in_ready=0. Drains normally. Popping the HALT entry -> HALTED.
  - HALTED: halted=1, in_ready=0, FIFO empty. Left only by rst.
- flush (synchronous, highest priority):
  - Empties the FIFO in the same cycle; out_valid=0 the next cycle.
  - Any push and any pop that cycle are discarded.
  - RUN/HALT_PEND -> RUN. Ignored in HALTED.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
  - Full: in_ready=0, but a pop still occurs.
  - Empty: out_valid=0, and out_ready is ignored.
- rst asserted mid-transfer: immediate return to reset values, with no partial entry retained.

Optional Feature:
IMM_DECODE_STATS_EN: when defined, adds the output issue_cnt[15:0].
- Counts pops; saturates at 16'hFFFF; cleared by rst only, not by flush.
- When undefined, the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then push in_inst=16'h4007 (ADDI, opcode 01000, imm 5'b00111), pc=16'h0010, out_ready=1 -> next cycle out_valid=1, out_ext_sel=3'b010, out_imm=16'h0007, out_pc=16'h0010.
- Push 16'h601F (opcode 01100, imm8=8'h1F) then 16'h60F0 (imm8=8'hF0) -> out_imm=16'h001F then 16'hFFF0, out_ext_sel=3'b100. Push 16'h2405 (J, imm11=11'h405) -> out_ext_sel=3'b110, out_imm=16'hFC05. Push 16'h90FF (SLBI) -> out_ext_sel=3'b001, out_imm=16'h00FF.
- out_ready=0, push DEPTH=2 instructions -> in_ready=0 after the second; third in_valid ignored. Raise out_ready for 1 cycle -> one pop, in_ready=1 next cycle. Order preserved.
- Push NOP (16'h0800), HALT (16'h0000), then in_valid held with 16'h4001 -> in_ready=0 after HALT. Drain -> halted=1 the cycle after the HALT pop; 16'h4001 never appears.
- 2 entries queued, HALT_PEND, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, state RUN, the flush-cycle input dropped.
- With IMM_DECODE_STATS_EN: 5 pops, 1 flush -> issue_cnt=5. After rst -> issue_cnt=0.
